// File: rtl/hps_reset_pkg.sv
// Shared constants for the HPS reset request sequencer: FSM state codes,
// request kinds as reported on last_kind, and issp_req bit positions.
package hps_reset_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_ASSERT   = 3'd1;
    localparam state_t ST_WAIT_ACK = 3'd2;
    localparam state_t ST_WAIT_REL = 3'd3;
    localparam state_t ST_HOLDOFF  = 3'd4;

    localparam logic [1:0] KIND_NONE  = 2'd0;
    localparam logic [1:0] KIND_COLD  = 2'd1;
    localparam logic [1:0] KIND_WARM  = 2'd2;
    localparam logic [1:0] KIND_DEBUG = 2'd3;

    localparam int REQ_COLD  = 0;
    localparam int REQ_WARM  = 1;
    localparam int REQ_DEBUG = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/hps_reset_sync_edge.sv
// Multi-bit synchroniser with a registered rising-edge output.
// Edges are only reported once the chain and the history flop hold real
// samples, so a level already high when reset releases never looks like an edge.
module hps_reset_sync_edge
    import hps_reset_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [STAGES-1:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0]             hist;
    logic [STAGES:0]              arm;

    assign level = chain[STAGES-1];

    // Synchronise, keep one sample of history, and flag 0->1 once armed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
            hist  <= '0;
            arm   <= '0;
            rise  <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            hist  <= chain[STAGES-1];
            arm   <= {arm[STAGES-1:0], 1'b1};
            rise  <= arm[STAGES] ? (chain[STAGES-1] & ~hist) : '0;
        end
    end

endmodule

// File: rtl/hps_reset_req_sequencer.sv
// Turns ISSP reset-request edges into fixed-width active-low pulses on the
// HPS f2h reset request inputs, one request at a time, cold > warm > debug.
// Cold/warm completion is confirmed through hps_fpga_reset (assert, then
// release), each phase bounded by ACK_TIMEOUT; a holdoff follows every request.
//
// state       | meaning
// ST_IDLE     | nothing in progress; grants the top pending request
// ST_ASSERT   | selected req_n held low for PULSE_CYCLES
// ST_WAIT_ACK | cold/warm: waiting for hps_fpga_reset to assert
// ST_WAIT_REL | cold/warm: waiting for hps_fpga_reset to release
// ST_HOLDOFF  | quiet time before the next grant
module hps_reset_req_sequencer
    import hps_reset_pkg::*;
#(
    parameter int PULSE_CYCLES   = 16,
    parameter int ACK_TIMEOUT    = 1024,
    parameter int HOLDOFF_CYCLES = 256,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] issp_req,
    input  logic       hps_fpga_reset,
    output logic       f2h_cold_reset_req_n,
    output logic       f2h_warm_reset_req_n,
    output logic       f2h_debug_reset_req_n,
    output logic       busy,
    output logic [2:0] pending,
    output logic [1:0] last_kind,
    output logic       ack_timeout,
    output logic [7:0] grant_count
);

    localparam int CNT_MAX = max3(PULSE_CYCLES, ACK_TIMEOUT, HOLDOFF_CYCLES);
    localparam int CW      = $clog2(CNT_MAX + 1);

    logic [2:0]    req_rise;
    logic [2:0]    req_level_unused;
    logic          ack_lvl;
    logic          ack_rise_unused;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    kind_nx;
    logic [2:0]    clr_mask;
    logic          grant;
    logic          timeout_set;

    hps_reset_sync_edge #(.WIDTH(3), .STAGES(SYNC_STAGES)) u_req_sync (
        .clk   (clk),
        .reset (reset),
        .din   (issp_req),
        .level (req_level_unused),
        .rise  (req_rise)
    );

    hps_reset_sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .din   (hps_fpga_reset),
        .level (ack_lvl),
        .rise  (ack_rise_unused)
    );

    // Next-state, counter reload and grant selection.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        kind_nx     = last_kind;
        clr_mask    = 3'b000;
        grant       = 1'b0;
        timeout_set = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pending != 3'b000) begin
                    grant    = 1'b1;
                    state_nx = ST_ASSERT;
                    cnt_nx   = CW'(PULSE_CYCLES - 1);
                    if (pending[REQ_COLD]) begin
                        kind_nx            = KIND_COLD;
                        clr_mask[REQ_COLD] = 1'b1;
                    end else if (pending[REQ_WARM]) begin
                        kind_nx            = KIND_WARM;
                        clr_mask[REQ_WARM] = 1'b1;
                    end else begin
                        kind_nx             = KIND_DEBUG;
                        clr_mask[REQ_DEBUG] = 1'b1;
                    end
                end
            end
            ST_ASSERT: begin
                if (cnt == '0) begin
                    if (last_kind == KIND_DEBUG) begin
                        state_nx = ST_HOLDOFF;
                        cnt_nx   = CW'(HOLDOFF_CYCLES - 1);
                    end else begin
                        state_nx = ST_WAIT_ACK;
                        cnt_nx   = CW'(ACK_TIMEOUT - 1);
                    end
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            ST_WAIT_ACK: begin
                if (ack_lvl) begin
                    state_nx = ST_WAIT_REL;
                    cnt_nx   = CW'(ACK_TIMEOUT - 1);
                end else if (cnt == '0) begin
                    timeout_set = 1'b1;
                    state_nx    = ST_HOLDOFF;
                    cnt_nx      = CW'(HOLDOFF_CYCLES - 1);
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            ST_WAIT_REL: begin
                if (!ack_lvl) begin
                    state_nx = ST_HOLDOFF;
                    cnt_nx   = CW'(HOLDOFF_CYCLES - 1);
                end else if (cnt == '0) begin
                    timeout_set = 1'b1;
                    state_nx    = ST_HOLDOFF;
                    cnt_nx      = CW'(HOLDOFF_CYCLES - 1);
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            ST_HOLDOFF: begin
                if (cnt == '0) begin
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // State, status and request outputs, all registered from the next state.
    // A new edge on the bit being granted survives the clear (set wins).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                 <= ST_IDLE;
            cnt                   <= '0;
            busy                  <= 1'b0;
            pending               <= 3'b000;
            last_kind             <= KIND_NONE;
            ack_timeout           <= 1'b0;
            grant_count           <= 8'd0;
            f2h_cold_reset_req_n  <= 1'b1;
            f2h_warm_reset_req_n  <= 1'b1;
            f2h_debug_reset_req_n <= 1'b1;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            busy      <= (state_nx != ST_IDLE);
            pending   <= (pending & ~clr_mask) | req_rise;
            last_kind <= kind_nx;
            if (grant) begin
                grant_count <= grant_count + 8'd1;
            end
            if (timeout_set) begin
                ack_timeout <= 1'b1;
            end
            f2h_cold_reset_req_n  <= ~((state_nx == ST_ASSERT) && (kind_nx == KIND_COLD));
            f2h_warm_reset_req_n  <= ~((state_nx == ST_ASSERT) && (kind_nx == KIND_WARM));
            f2h_debug_reset_req_n <= ~((state_nx == ST_ASSERT) && (kind_nx == KIND_DEBUG));
        end
    end

endmodule

// File: tb/tb_hps_reset_req_sequencer.sv
// Directed bench for hps_reset_req_sequencer with PULSE=4, TIMEOUT=20,
// HOLDOFF=8, two synchroniser stages. A small HPS model answers cold/warm
// pulses; a negedge monitor checks pulse widths and mutual exclusion.
module tb_hps_reset_req_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] issp_req = 3'b000;
    logic       hps_fpga_reset = 1'b0;
    logic       f2h_cold_reset_req_n;
    logic       f2h_warm_reset_req_n;
    logic       f2h_debug_reset_req_n;
    logic       busy;
    logic [2:0] pending;
    logic [1:0] last_kind;
    logic       ack_timeout;
    logic [7:0] grant_count;

    int checks = 0;
    int failures = 0;
    int overlap = 0;
    int run [3];
    int order_q [$];
    int pend_q [$];
    int hps_mode = 0;
    int rel_cnt = -1;
    int nb;

    hps_reset_req_sequencer #(
        .PULSE_CYCLES   (4),
        .ACK_TIMEOUT    (20),
        .HOLDOFF_CYCLES (8),
        .SYNC_STAGES    (2)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .issp_req              (issp_req),
        .hps_fpga_reset        (hps_fpga_reset),
        .f2h_cold_reset_req_n  (f2h_cold_reset_req_n),
        .f2h_warm_reset_req_n  (f2h_warm_reset_req_n),
        .f2h_debug_reset_req_n (f2h_debug_reset_req_n),
        .busy                  (busy),
        .pending               (pending),
        .last_kind             (last_kind),
        .ack_timeout           (ack_timeout),
        .grant_count           (grant_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse width, exclusivity and grant order, sampled on the falling edge.
    always @(negedge clk) begin
        logic [2:0] rq;
        int lows;
        rq = {f2h_debug_reset_req_n, f2h_warm_reset_req_n, f2h_cold_reset_req_n};
        if (reset) begin
            for (int k = 0; k < 3; k++) run[k] = 0;
        end else begin
            lows = 0;
            for (int k = 0; k < 3; k++) if (!rq[k]) lows++;
            if (lows > 1) overlap++;
            for (int k = 0; k < 3; k++) begin
                if (!rq[k]) begin
                    if (run[k] == 0) begin
                        order_q.push_back(k);
                        pend_q.push_back(int'(pending));
                    end
                    run[k]++;
                end else if (run[k] != 0) begin
                    chk("pulse_len", run[k], 4);
                    run[k] = 0;
                end
            end
        end
    end

    // HPS model: 5 cycles after a cold/warm pulse ends, assert reset for 10 cycles,
    // then count cycles from release to busy falling.
    initial begin
        forever begin
            @(posedge f2h_warm_reset_req_n or posedge f2h_cold_reset_req_n);
            if (hps_mode != 0 && !reset) begin
                repeat (5) @(posedge clk);
                #1 hps_fpga_reset = 1'b1;
                repeat (10) @(posedge clk);
                #1 hps_fpga_reset = 1'b0;
                rel_cnt = 0;
                while (busy && f2h_warm_reset_req_n && f2h_cold_reset_req_n && rel_cnt < 50) begin
                    @(posedge clk);
                    rel_cnt++;
                    #1;
                end
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] v);
        @(posedge clk); #1 issp_req = v;
    endtask

    task automatic run_until_idle(input string tag);
        int n;
        n = 0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        while ((busy || pending != 3'b000) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {busy, pending}, 0);
    endtask

    task automatic count_busy(output int n);
        int w;
        w = 0;
        n = 0;
        while (!busy && w < 30) begin @(negedge clk); w++; end
        while (busy && n < 200) begin @(negedge clk); n++; end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_n", {f2h_debug_reset_req_n, f2h_warm_reset_req_n, f2h_cold_reset_req_n}, 3'b111);
        chk("rst_busy", busy, 0);
        chk("rst_pending", pending, 0);
        chk("rst_kind", last_kind, 0);
        chk("rst_timeout", ack_timeout, 0);
        chk("rst_gcount", grant_count, 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (5) @(posedge clk);

        // Warm request with responding HPS
        hps_mode = 1;
        drive(3'b010);
        run_until_idle("warm_idle");
        chk("warm_kind", last_kind, 2);
        chk("warm_gcount", grant_count, 1);
        chk("warm_rel_to_idle", rel_cnt, 11);
        chk("warm_timeout", ack_timeout, 0);
        drive(3'b000);

        // Simultaneous cold+warm+debug
        apply_reset();
        order_q.delete();
        pend_q.delete();
        drive(3'b111);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("all_pending", pending, 7);
        run_until_idle("all_idle");
        chk("all_ngrants", order_q.size(), 3);
        chk("all_order0", order_q[0], 0);
        chk("all_order1", order_q[1], 1);
        chk("all_order2", order_q[2], 2);
        chk("all_pend0", pend_q[0], 6);
        chk("all_pend1", pend_q[1], 4);
        chk("all_pend2", pend_q[2], 0);
        chk("all_gcount", grant_count, 3);
        chk("all_timeout", ack_timeout, 0);
        drive(3'b000);

        // Debug request: no ack phase
        repeat (3) @(posedge clk);
        drive(3'b100);
        count_busy(nb);
        chk("dbg_busy_len", nb, 12);
        chk("dbg_kind", last_kind, 3);
        chk("dbg_timeout", ack_timeout, 0);
        chk("dbg_gcount", grant_count, 4);
        drive(3'b000);

        // Cold request, HPS silent -> timeout
        hps_mode = 0;
        repeat (3) @(posedge clk);
        drive(3'b001);
        count_busy(nb);
        chk("cold_to_busy_len", nb, 32);
        chk("cold_to_flag", ack_timeout, 1);
        chk("cold_to_kind", last_kind, 1);
        chk("cold_to_gcount", grant_count, 5);
        drive(3'b000);

        // HPS reset while idle is ignored
        @(posedge clk); #1 hps_fpga_reset = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("hps_idle_busy", busy, 0);
        chk("hps_idle_gcount", grant_count, 5);
        @(posedge clk); #1 hps_fpga_reset = 1'b0;
        repeat (5) @(posedge clk);

        // Sticky timeout across a later good request
        hps_mode = 1;
        drive(3'b010);
        run_until_idle("sticky_idle");
        chk("sticky_timeout", ack_timeout, 1);
        chk("sticky_gcount", grant_count, 6);
        drive(3'b000);

        // Level high through reset release: no grant until a fresh edge
        drive(3'b010);
        apply_reset();
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("held_gcount", grant_count, 0);
        chk("held_pending", pending, 0);
        chk("held_busy", busy, 0);
        drive(3'b000);
        repeat (5) @(posedge clk);
        drive(3'b010);
        run_until_idle("retoggle_idle");
        chk("retoggle_gcount", grant_count, 1);
        chk("retoggle_kind", last_kind, 2);
        drive(3'b000);

        // Reset in the second cycle of a cold pulse
        hps_mode = 0;
        apply_reset();
        drive(3'b101);
        nb = 0;
        @(negedge clk);
        while (f2h_cold_reset_req_n && nb < 30) begin @(negedge clk); nb++; end
        chk("mid_cold_low", f2h_cold_reset_req_n, 0);
        chk("mid_pre_gcount", grant_count, 1);
        chk("mid_pre_pending", pending, 4);
        @(posedge clk); #1 reset = 1'b1;
        #1;
        chk("mid_cold_n", f2h_cold_reset_req_n, 1);
        chk("mid_busy", busy, 0);
        chk("mid_pending", pending, 0);
        chk("mid_kind", last_kind, 0);
        chk("mid_gcount", grant_count, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("mid_held_gcount", grant_count, 0);
        drive(3'b000);
        repeat (5) @(posedge clk);

        // 300 debug grants wrap the counter
        for (int i = 0; i < 300; i++) begin
            drive(3'b100);
            repeat (2) @(posedge clk);
            #1 issp_req = 3'b000;
            run_until_idle("wrap_idle");
        end
        chk("wrap_gcount", grant_count, 44);
        chk("wrap_timeout", ack_timeout, 0);

        chk("overlap", overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
